// File: rtl/axi_write_master_pkg.sv
// Shared AXI write-channel encodings and FSM state type for axi_write_master.
package axi_write_master_pkg;

  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_32B      = 3'b101;
  localparam logic       AXI_LOCK_NORMAL   = 1'b0;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;
  localparam logic [3:0] AXI_QOS_DEFAULT   = 4'b0000;

  // Low address bits cleared to align every burst to a full 32-byte beat
  localparam int unsigned ALIGN_BITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } wm_state_e;

endpackage

// File: rtl/axi_write_master.sv
// AXI write master: one AW per command, in-order W beat pass-through,
// B retirement with a bounded count of outstanding writes.
module axi_write_master
  import axi_write_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 33,
  parameter int unsigned DATA_WIDTH      = 256,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned AXI_ID          = 0,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_in,
  input  logic [7:0]              wr_len_in,
  input  logic                    wr_info_valid_in,
  output logic                    wr_info_rdy_out,
  input  logic [DATA_WIDTH-1:0]   wr_data_in,
  input  logic                    wr_data_valid_in,
  output logic                    wr_data_rdy_out,
  output logic                    wr_idle_out,
  output logic                    wr_err_out,
  input  logic                    axi_awready_in,
  output logic [ID_WIDTH-1:0]     axi_awid_out,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr_out,
  output logic [7:0]              axi_awlen_out,
  output logic                    axi_awvalid_out,
  output logic [1:0]              axi_awburst_out,
  output logic [2:0]              axi_awsize_out,
  output logic                    axi_awlock_out,
  output logic [3:0]              axi_awcache_out,
  output logic [2:0]              axi_awprot_out,
  output logic [3:0]              axi_awqos_out,
  input  logic                    axi_wready_in,
  output logic [DATA_WIDTH-1:0]   axi_wdata_out,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb_out,
  output logic                    axi_wlast_out,
  output logic                    axi_wvalid_out,
  input  logic [ID_WIDTH-1:0]     axi_bid_in,
  input  logic [1:0]              axi_bresp_in,
  input  logic                    axi_bvalid_in,
  output logic                    axi_bready_out
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OUT_W      = 4;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  wm_state_e               state_q, state_d;
  logic                    awvalid_q, awvalid_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [7:0]              awlen_q, awlen_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic [OUT_W-1:0]        outstanding_q, outstanding_d;
  logic                    err_q, err_d;

  logic info_rdy_c, in_data_c, wlast_c, aw_hs_c, b_hs_c, bready_c;
  logic bid_unused;

  // Response ID and the sub-beat address bits carry no information here
  assign bid_unused = ^{axi_bid_in, wr_addr_in[ALIGN_BITS-1:0]};

  assign bready_c = ~rst;

  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    awaddr_d      = awaddr_q;
    awlen_d       = awlen_q;
    beat_cnt_d    = beat_cnt_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;
    info_rdy_c    = 1'b0;
    in_data_c     = 1'b0;
    wlast_c       = 1'b0;
    aw_hs_c       = awvalid_q & axi_awready_in;
    b_hs_c        = axi_bvalid_in & bready_c;

    unique case (state_q)
      ST_IDLE: begin
        info_rdy_c = ~rst & (outstanding_q < OUT_MAX);
        if (info_rdy_c && wr_info_valid_in) begin
          awaddr_d  = {wr_addr_in[ADDR_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
          awlen_d   = wr_len_in;
          awvalid_d = 1'b1;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (aw_hs_c) begin
          awvalid_d  = 1'b0;
          beat_cnt_d = 8'd0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        in_data_c = 1'b1;
        wlast_c   = (beat_cnt_q == awlen_q);
        if (wr_data_valid_in && axi_wready_in) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (wlast_c) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Simultaneous AW and B cancel; a stray B at zero saturates and flags an error
    if (aw_hs_c && !b_hs_c) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (b_hs_c && !aw_hs_c && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end
    if (b_hs_c && ((outstanding_q == '0) || (axi_bresp_in != AXI_RESP_OKAY))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      awvalid_q     <= 1'b0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      beat_cnt_q    <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
      beat_cnt_q    <= beat_cnt_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign wr_info_rdy_out = info_rdy_c;
  assign wr_data_rdy_out = in_data_c & axi_wready_in;
  assign wr_idle_out     = (state_q == ST_IDLE) && (outstanding_q == '0);
  assign wr_err_out      = err_q;

  assign axi_awid_out    = ID_WIDTH'(AXI_ID);
  assign axi_awaddr_out  = awaddr_q;
  assign axi_awlen_out   = awlen_q;
  assign axi_awvalid_out = awvalid_q;
  assign axi_awburst_out = AXI_BURST_INCR;
  assign axi_awsize_out  = AXI_SIZE_32B;
  assign axi_awlock_out  = AXI_LOCK_NORMAL;
  assign axi_awcache_out = AXI_CACHE_DEFAULT;
  assign axi_awprot_out  = AXI_PROT_DEFAULT;
  assign axi_awqos_out   = AXI_QOS_DEFAULT;

  assign axi_wdata_out   = wr_data_in;
  assign axi_wstrb_out   = {STRB_WIDTH{1'b1}};
  assign axi_wlast_out   = wlast_c;
  assign axi_wvalid_out  = in_data_c & wr_data_valid_in;
  assign axi_bready_out  = bready_c;

endmodule
